// File: rtl/sha256_pkg.sv
// SHA-256 compression constants, working-variable bundle and round functions.
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ROUND,
        FINAL
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ch(
        input logic [31:0] e,
        input logic [31:0] f,
        input logic [31:0] g
    );
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] c
    );
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // Word-wise mod 2^32 add of chaining value and working variables.
    function automatic logic [255:0] hash_add(
        input logic [255:0] hv,
        input work_t v
    );
        logic [255:0] vv;
        logic [255:0] r;
        vv = v;
        for (int i = 0; i < 8; i++) begin
            r[i*32 +: 32] = hv[i*32 +: 32] + vv[i*32 +: 32];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
module sha256_round
    import sha256_pkg::*;
(
    input  work_t       cur,
    input  logic [31:0] k,
    input  logic [31:0] w,
    output work_t       nxt
);

    logic [31:0] t1;
    logic [31:0] t2;

    assign t1 = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
    assign t2 = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);

    assign nxt = '{
        a: t1 + t2,
        b: cur.a,
        c: cur.b,
        d: cur.c,
        e: cur.d + t1,
        f: cur.e,
        g: cur.f,
        h: cur.g
    };

endmodule

// File: rtl/sha256_compress.sv
// Iterative SHA-256 block compression, one round per clock.
module sha256_compress
    import sha256_pkg::*;
#(
    parameter int W_LENGTH = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    w_vector_complete,
    input  logic [W_LENGTH*32-1:0]  w_vector,
    input  logic                    use_init,
    input  logic [255:0]            prev_hash,
    output logic                    busy,
    output logic [$clog2(W_LENGTH)-1:0] round_index,
    output logic                    hash_valid,
    output logic [255:0]            hash
);

    localparam int CW = $clog2(W_LENGTH);

    state_t                 state;
    logic [W_LENGTH*32-1:0] w_reg;
    logic [255:0]           h_reg;
    work_t                  v;
    work_t                  v_nxt;
    logic [CW-1:0]          cnt;
    logic [31:0]            w_cur;

    assign w_cur       = w_reg[{cnt, 5'd0} +: 32];
    assign round_index = cnt;

    sha256_round u_round (
        .cur (v),
        .k   (K[cnt]),
        .w   (w_cur),
        .nxt (v_nxt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            hash_valid <= 1'b0;
            hash       <= '0;
            cnt        <= '0;
            v          <= '0;
        end else begin
            hash_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Latch inputs at accept so upstream is free from LOAD on.
                    if (start && w_vector_complete) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                        w_reg <= w_vector;
                        h_reg <= use_init ? SHA256_IV : prev_hash;
                    end
                end
                LOAD: begin
                    v     <= work_t'(h_reg);
                    cnt   <= '0;
                    state <= ROUND;
                end
                ROUND: begin
                    v   <= v_nxt;
                    cnt <= cnt + 1'b1;
                    // Sum is registered with the last round so the pulse lands in FINAL.
                    if (cnt == CW'(W_LENGTH - 1)) begin
                        state      <= FINAL;
                        hash       <= hash_add(h_reg, v_nxt);
                        hash_valid <= 1'b1;
                    end
                end
                FINAL: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_compress.sv
// Directed scoreboard bench for sha256_compress against known digests.
module tb_sha256_compress;

    logic          clock;
    logic          reset;
    logic          start;
    logic          w_vector_complete;
    logic [2047:0] w_vector;
    logic          use_init;
    logic [255:0]  prev_hash;
    logic          busy;
    logic [5:0]    round_index;
    logic          hash_valid;
    logic [255:0]  hash;

    sha256_compress #(.W_LENGTH(64)) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .w_vector_complete (w_vector_complete),
        .w_vector          (w_vector),
        .use_init          (use_init),
        .prev_hash         (prev_hash),
        .busy              (busy),
        .round_index       (round_index),
        .hash_valid        (hash_valid),
        .hash              (hash)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [255:0] h;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    localparam logic [255:0] D_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_B1 =
        256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
    localparam logic [255:0] D_B2 =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Message schedule expansion: block word 0 is at the MSB.
    function automatic logic [2047:0] sched(input logic [511:0] blk);
        logic [31:0]   w [64];
        logic [2047:0] r;
        logic [31:0]   s0;
        logic [31:0]   s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int t = 0; t < 64; t++) r[t*32 +: 32] = w[t];
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] got,
                       input logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    always @(negedge clock) begin
        if (hash_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid got %h want none", hash);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (hash !== e.h) begin
                    errors++;
                    $display("FAIL digest got %h want %h", hash, e.h);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL latency got %0d want %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic launch(input logic [2047:0] w, input bit init,
                          input logic [255:0] prev, input logic [255:0] exp,
                          input bit push);
        @(negedge clock);
        chk("idle_busy", 256'(busy), 256'd0);
        w_vector          = w;
        use_init          = init;
        prev_hash         = prev;
        start             = 1'b1;
        w_vector_complete = 1'b1;
        @(posedge clock);
        #1;
        chk("accept_busy", 256'(busy), 256'd1);
        if (push) sb.push_back('{exp, cyc + 65});
        @(negedge clock);
        start             = 1'b0;
        w_vector_complete = 1'b0;
        w_vector          = ~w;
        prev_hash         = ~prev;
    endtask

    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (hash_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout got no hash_valid want hash_valid", name);
        end
    endtask

    task automatic wait_round(input logic [5:0] r);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (round_index == r) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL round_wait got %0d want %0d", round_index, r);
        end
    endtask

    logic [2047:0] w_abc;
    logic [2047:0] w_empty;
    logic [2047:0] w_b1;
    logic [2047:0] w_b2;

    initial begin
        w_abc   = sched({32'h61626380, 448'h0, 32'h00000018});
        w_empty = sched({32'h80000000, 480'h0});
        w_b1    = sched({32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000});
        w_b2    = sched({480'h0, 32'h000001c0});

        reset             = 1'b1;
        start             = 1'b0;
        w_vector_complete = 1'b0;
        w_vector          = '0;
        use_init          = 1'b0;
        prev_hash         = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_valid", 256'(hash_valid), 256'd0);
        chk("rst_hash", hash, 256'd0);
        chk("rst_round", 256'(round_index), 256'd0);
        reset = 1'b0;

        launch(w_abc, 1'b1, '0, D_ABC, 1'b1);
        wait_valid("abc");
        launch(w_empty, 1'b1, '0, D_EMPTY, 1'b1);
        wait_valid("empty");

        // Two-block chain, second start in the first IDLE cycle.
        launch(w_b1, 1'b1, '0, D_B1, 1'b1);
        wait_valid("blk1");
        launch(w_b2, 1'b0, D_B1, D_B2, 1'b1);
        wait_valid("blk2");

        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            start             = 1'b1;
            w_vector_complete = 1'b0;
            w_vector          = w_abc;
            @(posedge clock);
            #1;
            chk("drop_busy", 256'(busy), 256'd0);
        end
        launch(w_abc, 1'b1, '0, D_ABC, 1'b1);
        wait_valid("late_accept");

        launch(w_abc, 1'b1, '0, D_ABC, 1'b0);
        wait_round(6'd30);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("abort_busy", 256'(busy), 256'd0);
        chk("abort_hash", hash, 256'd0);
        chk("abort_valid", 256'(hash_valid), 256'd0);
        chk("abort_round", 256'(round_index), 256'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (70) @(negedge clock);
        launch(w_abc, 1'b1, '0, D_ABC, 1'b1);
        wait_valid("post_abort");

        launch(w_abc, 1'b1, '0, D_ABC, 1'b1);
        wait_round(6'd10);
        w_vector          = {64{$urandom()}};
        prev_hash         = {8{$urandom()}};
        use_init          = 1'b0;
        start             = 1'b1;
        w_vector_complete = 1'b1;
        @(negedge clock);
        start             = 1'b0;
        w_vector_complete = 1'b0;
        wait_valid("perturb");

        repeat (5) @(negedge clock);
        chk("sb_empty", 256'(sb.size()), 256'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
